// File: rtl/conv_mac_ctrl.sv
// Purpose : sequences one N_TAPS window through the shared 8x8 multiplier and accumulates the products.
// Latency : 3*N_TAPS cycles from accepted start to done with a 1-cycle multiplier; each extra multiplier cycle adds one.
// Backpr. : start is only sampled in IDLE (no queueing); MUL waits indefinitely on mul_done.
//
// Ports:
//   clk, reset            rising-edge clock, asynchronous active-high reset
//   start                 window request, sampled only while idle
//   px_vec, wt_vec        tap k at bits [8k+7:8k]; latched on accepted start
//   acc_init              bias loaded into the accumulator on accepted start
//   busy, done            busy outside IDLE; done is a 1-cycle pulse with acc_out valid
//   acc_out               window sum, held until the next window completes or reset
//   mul_a, mul_b          multiplier operands for the current tap (0 outside MUL)
//   mul_start             multiplier start, high exactly while in MUL
//   mul_done, mul_result  multiplier handshake and 16-bit product
module conv_mac_ctrl #(
  parameter int N_TAPS = 9,
  parameter int ACC_W  = 20
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  start,
  input  logic [8*N_TAPS-1:0]   px_vec,
  input  logic [8*N_TAPS-1:0]   wt_vec,
  input  logic [ACC_W-1:0]      acc_init,
  output logic                  busy,
  output logic                  done,
  output logic [ACC_W-1:0]      acc_out,
  output logic [7:0]            mul_a,
  output logic [7:0]            mul_b,
  output logic                  mul_start,
  input  logic                  mul_done,
  input  logic [15:0]           mul_result
);

  localparam int K_W = (N_TAPS > 1) ? $clog2(N_TAPS) : 1;
  localparam logic [K_W-1:0] K_LAST = K_W'(N_TAPS - 1);

  typedef enum logic [1:0] {IDLE, MUL, GAP, DONE} state_t;

  state_t                state;
  logic [K_W-1:0]        k;
  logic [ACC_W-1:0]      acc;
  logic [8*N_TAPS-1:0]   px_q;
  logic [8*N_TAPS-1:0]   wt_q;
  logic [K_W-1:0]        k_nxt;
  logic [7:0]            nxt_a;
  logic [7:0]            nxt_b;

  // Tap selection as a compare-and-pick loop keeps the index in range for
  // any N_TAPS, including non-powers of two.
  function automatic logic [7:0] tap_sel(input logic [8*N_TAPS-1:0] vec,
                                         input logic [K_W-1:0]      idx);
    logic [7:0] r;
    r = '0;
    for (int i = 0; i < N_TAPS; i++) begin
      if (idx == K_W'(i)) r = vec[8*i +: 8];
    end
    return r;
  endfunction

  assign k_nxt = k + K_W'(1);
  assign nxt_a = tap_sel(px_q, k_nxt);
  assign nxt_b = tap_sel(wt_q, k_nxt);

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state     <= IDLE;
      k         <= '0;
      acc       <= '0;
      px_q      <= '0;
      wt_q      <= '0;
      acc_out   <= '0;
      done      <= 1'b0;
      busy      <= 1'b0;
      mul_start <= 1'b0;
      mul_a     <= '0;
      mul_b     <= '0;
    end else begin
      done <= 1'b0;
      case (state)
        IDLE: begin
          if (start) begin
            px_q      <= px_vec;
            wt_q      <= wt_vec;
            acc       <= acc_init;
            k         <= '0;
            // Operands come straight from the inputs so tap 0 is ready
            // in the first MUL cycle.
            mul_a     <= px_vec[7:0];
            mul_b     <= wt_vec[7:0];
            mul_start <= 1'b1;
            busy      <= 1'b1;
            state     <= MUL;
          end
        end
        MUL: begin
          if (mul_done) begin
            acc       <= acc + ACC_W'(mul_result);  // zero-extend, wraps
            mul_start <= 1'b0;
            mul_a     <= '0;
            mul_b     <= '0;
            state     <= GAP;
          end
        end
        GAP: begin
          // One cycle with start low lets the multiplier drop done;
          // mul_done is deliberately not looked at here.
          if (k == K_LAST) begin
            done    <= 1'b1;
            acc_out <= acc;
            state   <= DONE;
          end else begin
            k         <= k_nxt;
            mul_a     <= nxt_a;
            mul_b     <= nxt_b;
            mul_start <= 1'b1;
            state     <= MUL;
          end
        end
        DONE: begin
          busy  <= 1'b0;
          state <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule
